// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad scanner.
// Holds the scan FSM state encoding, the event FIFO depth used when
// KEYPAD_FIFO_EN is defined, and the key-code arithmetic.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    localparam int KEYPAD_FIFO_DEPTH = 4;

    // Flat key number: rows are laid out one after another, NCOLS keys each.
    function automatic int key_code_of(input int row_idx, input int col_idx, input int ncols);
        return row_idx * ncols + col_idx;
    endfunction

endpackage

// File: rtl/keypad_sync_n.sv
// sync_n: STAGES-deep, WIDTH-wide flop chain for asynchronous pin inputs.
// The clear value is all ones, the idle level of the pulled-up columns, so
// a freshly reset chain never looks like a pressed key.
module sync_n #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    // Shift the raw pins through the chain; the last stage is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '1;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with debounce and one event per press.
// Drives one row low at a time, samples synchronized columns on each scan tick,
// locks onto the first key seen and reports it through a valid/ready port.
// Build option: KEYPAD_FIFO_EN replaces the single holding register with a
// 4-entry event FIFO.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | walking rows, waiting for any column low
// DEBOUNCE | row locked, counting ticks with the candidate column low
// HELD     | key accepted and reported, waiting for candidate to open
// RELEASE  | counting ticks with the candidate column high
module keypad_scanner #(
    parameter int  NROWS       = 4,
    parameter int  NCOLS       = 4,
    parameter int  SCAN_DIV    = 1000,
    parameter int  DEBOUNCE    = 4,
    parameter int  SYNC_STAGES = 3,
    localparam int KW          = $clog2(NROWS * NCOLS)
) (
    input  logic             clk,
    input  logic             resetInv,
    input  logic [NCOLS-1:0] col,
    output logic [NROWS-1:0] row,
    output logic [KW-1:0]    key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             overrun
);

    import keypad_pkg::*;

    localparam int RW   = $clog2(NROWS);
    localparam int CI   = $clog2(NCOLS);
    localparam int CNTW = $clog2(DEBOUNCE + 1);
    localparam int DIVW = $clog2(SCAN_DIV);

    localparam logic [NROWS-1:0] ROW_RST = ~(NROWS'(1));
    localparam logic [CNTW-1:0]  DB_LAST = CNTW'(DEBOUNCE - 1);
    localparam logic [DIVW-1:0]  DIV_TOP = DIVW'(SCAN_DIV - 1);

    logic [DIVW-1:0]  div_cnt;
    logic             tick;
    logic [NCOLS-1:0] col_sync;
    logic [CI-1:0]    low_idx;
    logic             any_low;
    logic             cand_low;
    scan_state_t      state;
    logic [RW-1:0]    row_idx;
    logic [RW-1:0]    row_idx_nxt;
    logic [NROWS-1:0] row_nxt;
    logic [CI-1:0]    cand;
    logic [CNTW-1:0]  cnt;
    logic             emit;
    logic [CI-1:0]    emit_col;
    logic [KW-1:0]    emit_code;

    // Scan tick generator: free-running 0..SCAN_DIV-1.
    always_ff @(posedge clk or negedge resetInv) begin
        if (!resetInv) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_TOP);

    sync_n #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (NCOLS)
    ) u_sync (
        .clk   (clk),
        .rst_n (resetInv),
        .d     (col),
        .q     (col_sync)
    );

    // Lowest-index closed column on the currently driven row.
    always_comb begin
        low_idx = '0;
        for (int i = NCOLS - 1; i >= 0; i--) begin
            if (!col_sync[i]) begin
                low_idx = CI'(i);
            end
        end
    end

    assign any_low     = ~&col_sync;
    assign cand_low    = ~col_sync[cand];
    assign row_idx_nxt = (row_idx == RW'(NROWS - 1)) ? '0 : row_idx + 1'b1;
    assign row_nxt     = ~(NROWS'(1) << row_idx_nxt);

    // An event fires on the tick that completes the press count; with
    // DEBOUNCE=1 the very first sighting in SCAN already completes it.
    assign emit = tick &&
                  (((state == SCAN) && any_low && (DEBOUNCE == 1)) ||
                   ((state == keypad_pkg::DEBOUNCE) && cand_low && (cnt == DB_LAST)));
    assign emit_col  = (state == SCAN) ? low_idx : cand;
    assign emit_code = KW'(key_code_of(int'(row_idx), int'(emit_col), NCOLS));

    // Scan/debounce FSM; row drive and key_held are registered alongside state.
    always_ff @(posedge clk or negedge resetInv) begin
        if (!resetInv) begin
            state    <= SCAN;
            row_idx  <= '0;
            row      <= ROW_RST;
            cand     <= '0;
            cnt      <= '0;
            key_held <= 1'b0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        cand <= low_idx;
                        cnt  <= CNTW'(1);
                        if (DEBOUNCE == 1) begin
                            key_held <= 1'b1;
                            state    <= HELD;
                        end else begin
                            state <= keypad_pkg::DEBOUNCE;
                        end
                    end else begin
                        row_idx <= row_idx_nxt;
                        row     <= row_nxt;
                    end
                end
                keypad_pkg::DEBOUNCE: begin
                    if (cand_low) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == DB_LAST) begin
                            key_held <= 1'b1;
                            state    <= HELD;
                        end
                    end else begin
                        state   <= SCAN;
                        row_idx <= row_idx_nxt;
                        row     <= row_nxt;
                    end
                end
                HELD: begin
                    if (!cand_low) begin
                        cnt <= CNTW'(1);
                        if (DEBOUNCE == 1) begin
                            key_held <= 1'b0;
                            state    <= SCAN;
                            row_idx  <= row_idx_nxt;
                            row      <= row_nxt;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!cand_low) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == DB_LAST) begin
                            key_held <= 1'b0;
                            state    <= SCAN;
                            row_idx  <= row_idx_nxt;
                            row      <= row_nxt;
                        end
                    end else begin
                        state <= HELD;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

`ifdef KEYPAD_FIFO_EN
    localparam int PW = $clog2(KEYPAD_FIFO_DEPTH);

    logic [KW-1:0] fifo_mem [KEYPAD_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          pop;
    logic          push;

    assign full      = (count == (PW+1)'(KEYPAD_FIFO_DEPTH));
    assign pop       = key_valid && key_ready;
    assign push      = emit && (!full || pop);
    assign key_valid = (count != '0);
    assign key_code  = fifo_mem[rd_ptr];

    // Event FIFO: a pop frees a slot in the same cycle, so full+pop+push is fine.
    always_ff @(posedge clk or negedge resetInv) begin
        if (!resetInv) begin
            for (int i = 0; i < KEYPAD_FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= emit && full && !pop;
            if (push) begin
                fifo_mem[wr_ptr] <= emit_code;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
`else
    // Single holding register: an acceptance in the same cycle makes room.
    always_ff @(posedge clk or negedge resetInv) begin
        if (!resetInv) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_code  <= emit_code;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed stimulus on a simulated 4x4 keypad matrix with a
// cycle-level behavioural model compared against the DUT on every falling edge,
// plus literal expectations for the event codes of each scenario.
module tb_keypad_scanner;

    localparam int NROWS       = 4;
    localparam int NCOLS       = 4;
    localparam int SCAN_DIV    = 4;
    localparam int DEBOUNCE    = 3;
    localparam int SYNC_STAGES = 3;
    localparam int KW          = $clog2(NROWS * NCOLS);
`ifdef KEYPAD_FIFO_EN
    localparam int QDEPTH = 4;
`else
    localparam int QDEPTH = 1;
`endif

    logic                   clk;
    logic                   resetInv;
    logic [NCOLS-1:0]       col;
    logic [NROWS-1:0]       row;
    logic [KW-1:0]          key_code;
    logic                   key_valid;
    logic                   key_ready;
    logic                   key_held;
    logic                   overrun;
    logic [NROWS*NCOLS-1:0] pressed;

    int checks   = 0;
    int failures = 0;

    keypad_scanner #(
        .NROWS       (NROWS),
        .NCOLS       (NCOLS),
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE    (DEBOUNCE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .resetInv  (resetInv),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a closed switch pulls its column low while its row is driven low.
    always_comb begin
        col = '1;
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < NCOLS; c++) begin
                if (pressed[r*NCOLS + c] && !row[r]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_SEARCH  = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_DOWN    = 2;
    localparam int M_UPCHK   = 3;

    int               m_edges;
    int               m_row;
    int               m_mode;
    int               m_cand;
    int               m_agree;
    bit               m_held;
    bit               m_ovr;
    logic [NCOLS-1:0] m_pipe [SYNC_STAGES];
    int               evq [$];
    logic [NCOLS-1:0] col_n;
    bit               rdy_n;

    always @(posedge clk or negedge resetInv) begin
        logic [NCOLS-1:0] seen;
        bit               fire;
        int               code;
        int               lowc;
        if (!resetInv) begin
            m_edges = 0;
            m_row   = 0;
            m_mode  = M_SEARCH;
            m_cand  = 0;
            m_agree = 0;
            m_held  = 0;
            m_ovr   = 0;
            for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = '1;
            evq.delete();
        end else begin
            seen = m_pipe[SYNC_STAGES-1];
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = col_n;
            m_edges++;
            m_ovr = 0;
            fire  = 0;
            code  = 0;
            if (m_edges % SCAN_DIV == 0) begin
                case (m_mode)
                    M_SEARCH: begin
                        if (seen != '1) begin
                            lowc = 0;
                            for (int c = NCOLS - 1; c >= 0; c--) if (!seen[c]) lowc = c;
                            m_cand  = lowc;
                            m_agree = 1;
                            if (m_agree >= DEBOUNCE) begin
                                fire = 1; code = m_row * NCOLS + m_cand;
                                m_held = 1; m_mode = M_DOWN;
                            end else m_mode = M_CONFIRM;
                        end else m_row = (m_row + 1) % NROWS;
                    end
                    M_CONFIRM: begin
                        if (!seen[m_cand]) begin
                            m_agree++;
                            if (m_agree >= DEBOUNCE) begin
                                fire = 1; code = m_row * NCOLS + m_cand;
                                m_held = 1; m_mode = M_DOWN;
                            end
                        end else begin
                            m_mode = M_SEARCH;
                            m_row  = (m_row + 1) % NROWS;
                        end
                    end
                    M_DOWN: begin
                        if (seen[m_cand]) begin
                            m_agree = 1;
                            if (m_agree >= DEBOUNCE) begin
                                m_held = 0; m_mode = M_SEARCH; m_row = (m_row + 1) % NROWS;
                            end else m_mode = M_UPCHK;
                        end
                    end
                    default: begin
                        if (seen[m_cand]) begin
                            m_agree++;
                            if (m_agree >= DEBOUNCE) begin
                                m_held = 0; m_mode = M_SEARCH; m_row = (m_row + 1) % NROWS;
                            end
                        end else m_mode = M_DOWN;
                    end
                endcase
            end
            if (evq.size() > 0 && rdy_n) void'(evq.pop_front());
            if (fire) begin
                if (evq.size() < QDEPTH) evq.push_back(code);
                else m_ovr = 1;
            end
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    int got [$];
    int ovr_cnt = 0;

    always @(negedge clk) begin
        logic [NROWS-1:0] er;
        col_n = col;
        rdy_n = key_ready;
        er = '1;
        er[m_row] = 1'b0;
        check("row", row, er);
        check("key_valid", key_valid, evq.size() > 0);
        check("key_held", key_held, m_held);
        check("overrun", overrun, m_ovr);
        if (evq.size() > 0) check("key_code", key_code, evq[0]);
        if (!resetInv) check("reset_key_code", key_code, 0);
        if (resetInv && key_valid && key_ready) got.push_back(int'(key_code));
        if (resetInv && overrun) ovr_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_events(input string name, input int base, input int n, input int c0, input int c1);
        check({name, "_count"}, got.size() - base, n);
        if (got.size() > base) check({name, "_code0"}, got[base], c0);
        if (n > 1 && got.size() > base + 1) check({name, "_code1"}, got[base+1], c1);
    endtask

    initial begin
        int n0;
        int o0;
        resetInv  = 1'b0;
        key_ready = 1'b1;
        pressed   = '0;
        repeat (5) @(posedge clk);
        #1;
        resetInv = 1'b1;

        // reset values and row walk
        check("rst_row", row, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_overrun", overrun, 0);
        check("rst_code", key_code, 0);
        step(2);  check("walk0", row, 4'b1110);
        step(3);  check("walk1", row, 4'b1101);
        step(4);  check("walk2", row, 4'b1011);
        step(4);  check("walk3", row, 4'b0111);
        step(4);  check("walk4", row, 4'b1110);

        // clean press row 2 / col 1
        n0 = got.size();
        pressed[2*NCOLS + 1] = 1'b1;
        step(100);
        expect_events("press", n0, 1, 9, 0);
        check("press_held", key_held, 1);
        pressed = '0;
        step(40);
        check("release_held", key_held, 0);
        check("press_total", got.size() - n0, 1);

        // bounce on row 0 / col 3, then a stable closure
        n0 = got.size();
        pressed[3] = 1'b1;
        step(4);
        pressed = '0;
        step(8);
        pressed[3] = 1'b1;
        step(100);
        expect_events("bounce", n0, 1, 3, 0);
        pressed = '0;
        step(40);

        // two keys on row 1
        n0 = got.size();
        pressed[1*NCOLS + 2] = 1'b1;
        pressed[1*NCOLS + 0] = 1'b1;
        step(100);
        expect_events("twokeys", n0, 1, 4, 0);
        pressed = '0;
        step(40);

        // backpressure: key 5 then key 6 with the consumer stalled
        n0 = got.size();
        o0 = ovr_cnt;
        key_ready = 1'b0;
        pressed[5] = 1'b1;
        step(60);
        pressed = '0;
        step(40);
        pressed[6] = 1'b1;
        step(60);
        pressed = '0;
        step(40);
        check("bp_valid", key_valid, 1);
        check("bp_code", key_code, 5);
`ifdef KEYPAD_FIFO_EN
        check("bp_overrun", ovr_cnt - o0, 0);
`else
        check("bp_overrun", ovr_cnt - o0, 1);
`endif
        key_ready = 1'b1;
        step(10);
`ifdef KEYPAD_FIFO_EN
        expect_events("bp", n0, 2, 5, 6);
`else
        expect_events("bp", n0, 1, 5, 0);
`endif
        check("bp_drained", key_valid, 0);

        // reset mid-debounce on row 0 / col 2
        resetInv = 1'b0;
        pressed[2] = 1'b1;
        step(3);
        resetInv = 1'b1;
        n0 = got.size();
        step(8);
        resetInv = 1'b0;
        #1;
        check("midrst_valid", key_valid, 0);
        check("midrst_held", key_held, 0);
        check("midrst_row", row, 4'b1110);
        pressed = '0;
        step(3);
        resetInv = 1'b1;
        step(2);  check("restart_row0", row, 4'b1110);
        step(3);  check("restart_row1", row, 4'b1101);
        step(40);
        check("midrst_events", got.size() - n0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner: drives one keypad row low at a time and samples the column inputs through a multi-stage synchronizer. It debounces a single pressed key and emits one key-code event per press over a valid/ready handshake. It sits between the keypad pins and the display and decode logic, and replaces the fixed 4x4 divider, synchronizer and FSM arrangement with one configurable block.

## Interface
Parameters:
- NROWS, 4, number of keypad rows (≥2)
- NCOLS, 4, number of keypad columns (≥2)
- SCAN_DIV, 1000, clk cycles per scan tick (≥2)
- DEBOUNCE, 4, consecutive agreeing ticks needed to accept a press or a release (≥1)
- SYNC_STAGES, 3, column synchronizer depth (≥2)

Ports:
- clk  in  1  system clock; the block's only clock
- resetInv  in  1  asynchronous active-low reset
- col  in  NCOLS  column inputs, pulled up; 0 = key closed on the driven row
- row  out  NROWS  row drives, active-low, exactly one bit 0 at all times
- key_code  out  KW=$clog2(NROWS*NCOLS)  event code = row_idx*NCOLS + col_idx
- key_valid  out  1  event available
- key_ready  in  1  consumer accepts the event when key_valid && key_ready at posedge clk
- key_held  out  1  debounced key currently held
- overrun  out  1  one-cycle pulse: an event was dropped

## Operation
- Tick: counter runs 0..SCAN_DIV-1 and wraps; tick is asserted on the cycle the counter equals SCAN_DIV-1.
- Columns pass through SYNC_STAGES flops. The FSM samples the synchronized value only on a tick.
- States:
  - SCAN:
    - On a tick with no column low, advance row (idx NROWS-1 wraps to 0).
    - If any column is low, lock the row, latch the lowest-index low column as cand, set cnt=1, go to DEBOUNCE.
  - DEBOUNCE (row locked):
    - On a tick where cand is still low, cnt++.
    - When cnt reaches DEBOUNCE, emit the event, set key_held=1, go to HELD.
    - On a tick where cand is high, go to SCAN and advance row.
    - DEBOUNCE=1 goes from SCAN straight to the emit.
  - HELD: on a tick where cand is high, set cnt=1 and go to RELEASE. Other columns on the locked row are ignored.
  - RELEASE:
    - On a tick where cand is still high, cnt++.
    - When cnt reaches DEBOUNCE, clear key_held, go to SCAN and advance row.
    - On a tick where cand is low again, return to HELD.
- Only one key is reported per press; presses on other rows are invisible while a row is locked.
- Output handshake (single holding register):
  - An emit loads key_code and sets key_valid.
  - key_valid holds, with key_code stable, until a cycle with key_valid && key_ready.
  - An emit while key_valid is set and not being accepted that cycle is dropped and pulses overrun.
  - An emit in the same cycle as an acceptance loads the new code; it is not dropped.

## Timing
- Reset values: row = all ones except bit 0 = 0; key_code=0; key_valid=0; key_held=0; overrun=0. Tick counter, cnt, state (SCAN) and synchronizer flops are all cleared.
- Reset asserted mid-operation aborts any pending event; no event is emitted after reset deasserts until a full debounce completes.
- Settling: a row is driven for SCAN_DIV cycles before it is sampled. Row changes on the cycle after the sampling tick.
- Press latency: a closure that is stable from before a row's drive begins emits after DEBOUNCE ticks. key_valid rises the cycle after the final tick.
- Input-to-sample delay is SYNC_STAGES cycles. A bounce shorter than one tick is filtered only if it is not sampled.
- key_held falls the cycle after the DEBOUNCE-th release tick.

## Configuration
- KEYPAD_FIFO_EN defined: the holding register is replaced by a 4-entry event FIFO.
  - key_valid = FIFO not empty; key_code = head entry.
  - Pushing while full drops the event and pulses overrun.
  - A push and a pop in the same cycle while full succeed together.
- KEYPAD_FIFO_EN undefined: single holding register as described under Operation.

## Structure
- Package keypad_pkg holds:
  - state enum scan_state_t {SCAN, DEBOUNCE, HELD, RELEASE}
  - FIFO depth constant KEYPAD_FIFO_DEPTH=4
  - a function computing the key code from row and column indices
- Sub-module sync_n: the SYNC_STAGES-deep, NCOLS-wide synchronizer with async active-low clear.
- Tick counter, FSM and output stage stay in keypad_scanner.

## Test plan
Bench parameters: NROWS=4, NCOLS=4, SCAN_DIV=4, DEBOUNCE=3, key_ready=1 unless stated.
- Reset: resetInv=0 for 5 cycles, then release → row=4'b1110 and all outputs 0; row walks 1110→1101→1011→0111→1110, one step every 4 cycles.
- Clean press: close row 2 / col 1, hold for 100 cycles → exactly one event, key_code=9, key_held=1; after opening the key, key_held=0 three ticks later.
- Bounce: close row 0 / col 3 for 1 tick, open, then close stably → no event from the glitch; one event with code 3.
- Two keys on one row: close cols 2 and 0 on row 1 together → code 4, a single event.
- Backpressure: key_ready=0, press 5 then press 6 (separately, each released) → key_valid held with code 5, and overrun pulses once for 6. With KEYPAD_FIFO_EN defined, both codes are delivered in order and overrun stays 0.
- Reset mid-debounce: assert resetInv after 2 agreeing ticks → no event is emitted; scanning restarts at row 0.
